// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types, OCW2 command encodings and one-hot helpers
//                for the interrupt controller blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    // Acknowledge sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } ack_state_t;

    // OCW2 {R, SL, EOI} command field
    localparam logic [2:0] C_OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] C_OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] C_OCW2_NOP          = 3'b010;
    localparam logic [2:0] C_OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] C_OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] C_OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] C_OCW2_SET_PRIORITY = 3'b110;
    localparam logic [2:0] C_OCW2_ROT_SP_EOI   = 3'b111;

    // Level reported for an acknowledge with no pending request
    localparam logic [7:0] C_SPURIOUS_LEVEL = 8'h80;

    // Reset value of the lowest-priority pointer (IR0 highest priority)
    localparam logic [2:0] C_ROTATE_RESET = 3'b111;

    // Binary index of a one-hot byte; the highest set bit wins if not one-hot
    function automatic logic [2:0] encode8(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // One-hot byte from a binary level
    function automatic logic [7:0] onehot8(input logic [2:0] level);
        return 8'h01 << level;
    endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/interrupt_ack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_ack_controller
//  Description : Sequences the two-pulse INTA acknowledge, supplies the
//                vector byte, and generates EOI / priority-rotation commands
//                from OCW2 writes and automatic-EOI mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ack_controller
    import pic_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inta_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] highest_level_in_service,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    input  logic [4:0] icw2_vector,
    input  logic       auto_eoi,
    output logic       int_out,
    output logic [7:0] interrupt,
    output logic       latch_in_service,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic       freeze,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    ack_state_t state_q, state_d;
    logic       inta_q;
    logic [7:0] ack_level_q, ack_level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] interrupt_q, interrupt_d;
    logic       latch_q, latch_d;
    logic [7:0] eoi_q, eoi_d;
    logic [2:0] rotate_q, rotate_d;
    logic       auto_rotate_q, auto_rotate_d;

    logic       inta_fall;
    logic       inta_rise;
    logic       ack_done;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       unused_ocw2_bits;

    assign inta_fall        = inta_q & ~inta_n;
    assign inta_rise        = ~inta_q & inta_n;
    assign ocw2_cmd         = ocw2_data[7:5];
    assign ocw2_level       = ocw2_data[2:0];
    assign unused_ocw2_bits = ^ocw2_data[4:3];

    // Registered copy of INTA for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_n;
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ack_level_q   <= 8'h00;
            spurious_q    <= 1'b0;
            interrupt_q   <= 8'h00;
            latch_q       <= 1'b0;
            eoi_q         <= 8'h00;
            rotate_q      <= C_ROTATE_RESET;
            auto_rotate_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_level_q   <= ack_level_d;
            spurious_q    <= spurious_d;
            interrupt_q   <= interrupt_d;
            latch_q       <= latch_d;
            eoi_q         <= eoi_d;
            rotate_q      <= rotate_d;
            auto_rotate_q <= auto_rotate_d;
        end
    end

    // Acknowledge sequencer: capture on first INTA, finish on second
    always_comb begin
        state_d     = state_q;
        ack_level_d = ack_level_q;
        spurious_d  = spurious_q;
        interrupt_d = 8'h00;
        latch_d     = 1'b0;
        ack_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_d = ST_ACK1;
                    latch_d = 1'b1;
                    if (interrupt_request == 8'h00) begin
                        // Request withdrew before INTA: report level 7, set no ISR bit
                        ack_level_d = C_SPURIOUS_LEVEL;
                        spurious_d  = 1'b1;
                        interrupt_d = 8'h00;
                    end else begin
                        ack_level_d = interrupt_request;
                        spurious_d  = 1'b0;
                        interrupt_d = interrupt_request;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_d  = ST_IDLE;
                    ack_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // EOI and rotation: automatic path first, OCW2 merged on top
    always_comb begin
        eoi_d         = 8'h00;
        rotate_d      = rotate_q;
        auto_rotate_d = auto_rotate_q;

        if (ack_done && auto_eoi && !spurious_q) begin
            eoi_d = ack_level_q;
        end
        if (ack_done && auto_rotate_q) begin
            rotate_d = encode8(ack_level_q);
        end

        if (ocw2_write) begin
            case (ocw2_cmd)
                C_OCW2_NS_EOI: begin
                    eoi_d = eoi_d | highest_level_in_service;
                end
                C_OCW2_SP_EOI: begin
                    eoi_d = eoi_d | onehot8(ocw2_level);
                end
                C_OCW2_ROT_NS_EOI: begin
                    eoi_d = eoi_d | highest_level_in_service;
                    // Nothing in service means nothing to rotate around
                    if (highest_level_in_service != 8'h00) begin
                        rotate_d = encode8(highest_level_in_service);
                    end
                end
                C_OCW2_ROT_SP_EOI: begin
                    eoi_d    = eoi_d | onehot8(ocw2_level);
                    rotate_d = ocw2_level;
                end
                C_OCW2_SET_PRIORITY: begin
                    rotate_d = ocw2_level;
                end
                C_OCW2_ROT_AEOI_SET: begin
                    auto_rotate_d = 1'b1;
                end
                C_OCW2_ROT_AEOI_CLR: begin
                    auto_rotate_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign int_out          = (state_q == ST_IDLE) && (interrupt_request != 8'h00);
    assign freeze           = (state_q != ST_IDLE);
    assign interrupt        = interrupt_q;
    assign latch_in_service = latch_q;
    assign end_of_interrupt = eoi_q;
    assign priority_rotate  = rotate_q;
    assign data_out_enable  = (state_q == ST_ACK2);
    assign data_out         = (state_q == ST_ACK2) ? {icw2_vector, encode8(ack_level_q)} : 8'h00;

endmodule : interrupt_ack_controller
`default_nettype wire

// File: tb/tb_interrupt_ack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_ack_controller
//  Description : Directed self-checking bench for interrupt_ack_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_ack_controller;

    logic       clock;
    logic       reset;
    logic       inta_n;
    logic [7:0] interrupt_request;
    logic [7:0] highest_level_in_service;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic [4:0] icw2_vector;
    logic       auto_eoi;
    logic       int_out;
    logic [7:0] interrupt;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic       freeze;
    logic [7:0] data_out;
    logic       data_out_enable;

    int checks;
    int failures;

    interrupt_ack_controller dut (
        .clock                    (clock),
        .reset                    (reset),
        .inta_n                   (inta_n),
        .interrupt_request        (interrupt_request),
        .highest_level_in_service (highest_level_in_service),
        .ocw2_write               (ocw2_write),
        .ocw2_data                (ocw2_data),
        .icw2_vector              (icw2_vector),
        .auto_eoi                 (auto_eoi),
        .int_out                  (int_out),
        .interrupt                (interrupt),
        .latch_in_service         (latch_in_service),
        .end_of_interrupt         (end_of_interrupt),
        .priority_rotate          (priority_rotate),
        .freeze                   (freeze),
        .data_out                 (data_out),
        .data_out_enable          (data_out_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then settle away from the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset                    = 1'b1;
        inta_n                   = 1'b1;
        interrupt_request        = 8'h00;
        highest_level_in_service = 8'h00;
        ocw2_write               = 1'b0;
        ocw2_data                = 8'h00;
        icw2_vector              = 5'b00000;
        auto_eoi                 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Single OCW2 write strobe; registered results visible on return
    task automatic write_ocw2(input logic [7:0] value);
        ocw2_data  = value;
        ocw2_write = 1'b1;
        tick();
        ocw2_write = 1'b0;
    endtask

    // First INTA pulse; returns with the FSM in GAP
    task automatic first_inta();
        inta_n = 1'b0;
        tick();
        tick();
        inta_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (int_out !== 1'b0 || interrupt !== 8'h00 || latch_in_service !== 1'b0 ||
            end_of_interrupt !== 8'h00 || freeze !== 1'b0 || data_out !== 8'h00 ||
            data_out_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: int_out=%b int=%h latch=%b eoi=%h freeze=%b dout=%h oe=%b, required all 0",
                     int_out, interrupt, latch_in_service, end_of_interrupt, freeze, data_out, data_out_enable);
        end
        checks++;
        if (priority_rotate !== 3'b111) begin
            failures++;
            $display("FAIL reset_rotate: got %0d required 7", priority_rotate);
        end
    endtask

    task automatic test_ack_sequence();
        do_reset();
        icw2_vector       = 5'b01000;
        interrupt_request = 8'h08;
        #1;
        checks++;
        if (int_out !== 1'b1) begin
            failures++;
            $display("FAIL ack_int_out_idle: got %b required 1", int_out);
        end
        inta_n = 1'b0;
        tick();
        checks++;
        if (latch_in_service !== 1'b1 || interrupt !== 8'h08 || freeze !== 1'b1 || int_out !== 1'b0) begin
            failures++;
            $display("FAIL ack_capture: latch=%b int=%h freeze=%b int_out=%b required 1 08 1 0",
                     latch_in_service, interrupt, freeze, int_out);
        end
        tick();
        checks++;
        if (latch_in_service !== 1'b0 || interrupt !== 8'h00 || freeze !== 1'b1) begin
            failures++;
            $display("FAIL ack_latch_one_cycle: latch=%b int=%h freeze=%b required 0 00 1",
                     latch_in_service, interrupt, freeze);
        end
        inta_n = 1'b1;
        tick();
        checks++;
        if (freeze !== 1'b1 || data_out_enable !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL ack_gap: freeze=%b oe=%b dout=%h required 1 0 00", freeze, data_out_enable, data_out);
        end
        inta_n = 1'b0;
        tick();
        checks++;
        if (data_out !== 8'h43 || data_out_enable !== 1'b1 || freeze !== 1'b1) begin
            failures++;
            $display("FAIL ack_vector: dout=%h oe=%b freeze=%b required 43 1 1", data_out, data_out_enable, freeze);
        end
        inta_n = 1'b1;
        tick();
        checks++;
        if (freeze !== 1'b0 || data_out_enable !== 1'b0 || data_out !== 8'h00 || end_of_interrupt !== 8'h00) begin
            failures++;
            $display("FAIL ack_end: freeze=%b oe=%b dout=%h eoi=%h required 0 0 00 00",
                     freeze, data_out_enable, data_out, end_of_interrupt);
        end
    endtask

    task automatic test_aeoi();
        do_reset();
        auto_eoi          = 1'b1;
        interrupt_request = 8'h01;
        first_inta();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        checks++;
        if (end_of_interrupt !== 8'h01 || priority_rotate !== 3'd7) begin
            failures++;
            $display("FAIL aeoi_pulse: eoi=%h rot=%0d required 01 7", end_of_interrupt, priority_rotate);
        end
        tick();
        checks++;
        if (end_of_interrupt !== 8'h00) begin
            failures++;
            $display("FAIL aeoi_one_cycle: eoi=%h required 00", end_of_interrupt);
        end
    endtask

    task automatic test_ocw2_commands();
        do_reset();
        highest_level_in_service = 8'h20;
        write_ocw2(8'hA0);
        checks++;
        if (end_of_interrupt !== 8'h20 || priority_rotate !== 3'd5) begin
            failures++;
            $display("FAIL ocw2_rot_ns_eoi: eoi=%h rot=%0d required 20 5", end_of_interrupt, priority_rotate);
        end
        tick();
        checks++;
        if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd5) begin
            failures++;
            $display("FAIL ocw2_eoi_one_cycle: eoi=%h rot=%0d required 00 5", end_of_interrupt, priority_rotate);
        end
        write_ocw2(8'hC3);
        checks++;
        if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd3) begin
            failures++;
            $display("FAIL ocw2_set_priority: eoi=%h rot=%0d required 00 3", end_of_interrupt, priority_rotate);
        end
        write_ocw2(8'h62);
        checks++;
        if (end_of_interrupt !== 8'h04 || priority_rotate !== 3'd3) begin
            failures++;
            $display("FAIL ocw2_specific_eoi: eoi=%h rot=%0d required 04 3", end_of_interrupt, priority_rotate);
        end
        write_ocw2(8'h20);
        checks++;
        if (end_of_interrupt !== 8'h20) begin
            failures++;
            $display("FAIL ocw2_ns_eoi: eoi=%h required 20", end_of_interrupt);
        end
        write_ocw2(8'hE6);
        checks++;
        if (end_of_interrupt !== 8'h40 || priority_rotate !== 3'd6) begin
            failures++;
            $display("FAIL ocw2_rot_sp_eoi: eoi=%h rot=%0d required 40 6", end_of_interrupt, priority_rotate);
        end
        write_ocw2(8'h41);
        checks++;
        if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd6) begin
            failures++;
            $display("FAIL ocw2_nop: eoi=%h rot=%0d required 00 6", end_of_interrupt, priority_rotate);
        end
    endtask

    task automatic test_ns_eoi_empty();
        do_reset();
        highest_level_in_service = 8'h00;
        write_ocw2(8'hC2);
        write_ocw2(8'hA0);
        checks++;
        if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd2) begin
            failures++;
            $display("FAIL ns_eoi_empty: eoi=%h rot=%0d required 00 2", end_of_interrupt, priority_rotate);
        end
    endtask

    task automatic test_auto_rotate();
        do_reset();
        auto_eoi          = 1'b1;
        interrupt_request = 8'h40;
        write_ocw2(8'h80);
        first_inta();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        checks++;
        if (end_of_interrupt !== 8'h40 || priority_rotate !== 3'd6) begin
            failures++;
            $display("FAIL auto_rotate: eoi=%h rot=%0d required 40 6", end_of_interrupt, priority_rotate);
        end
        write_ocw2(8'h00);
        interrupt_request = 8'h04;
        first_inta();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        checks++;
        if (end_of_interrupt !== 8'h04 || priority_rotate !== 3'd6) begin
            failures++;
            $display("FAIL auto_rotate_cleared: eoi=%h rot=%0d required 04 6", end_of_interrupt, priority_rotate);
        end
    endtask

    task automatic test_back_to_back_ocw2_aeoi();
        do_reset();
        auto_eoi          = 1'b1;
        interrupt_request = 8'h02;
        write_ocw2(8'h80);
        first_inta();
        inta_n = 1'b0;
        tick();
        // Second INTA rises in the same cycle as an OCW2 rotate-on-specific-EOI
        inta_n     = 1'b1;
        ocw2_data  = 8'hE4;
        ocw2_write = 1'b1;
        tick();
        ocw2_write = 1'b0;
        checks++;
        if (end_of_interrupt !== 8'h12 || priority_rotate !== 3'd4) begin
            failures++;
            $display("FAIL aeoi_plus_ocw2: eoi=%h rot=%0d required 12 4", end_of_interrupt, priority_rotate);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        auto_eoi          = 1'b1;
        icw2_vector       = 5'b01000;
        interrupt_request = 8'h08;
        tick();
        interrupt_request = 8'h00;
        inta_n            = 1'b0;
        tick();
        checks++;
        if (interrupt !== 8'h00 || freeze !== 1'b1) begin
            failures++;
            $display("FAIL spurious_capture: int=%h freeze=%b required 00 1", interrupt, freeze);
        end
        tick();
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        checks++;
        if (data_out !== 8'h47 || data_out_enable !== 1'b1) begin
            failures++;
            $display("FAIL spurious_vector: dout=%h oe=%b required 47 1", data_out, data_out_enable);
        end
        inta_n = 1'b1;
        tick();
        checks++;
        if (end_of_interrupt !== 8'h00 || freeze !== 1'b0) begin
            failures++;
            $display("FAIL spurious_no_eoi: eoi=%h freeze=%b required 00 0", end_of_interrupt, freeze);
        end
    endtask

    task automatic test_reset_in_gap();
        do_reset();
        auto_eoi          = 1'b1;
        interrupt_request = 8'h10;
        write_ocw2(8'hC3);
        first_inta();
        checks++;
        if (freeze !== 1'b1) begin
            failures++;
            $display("FAIL gap_reached: freeze=%b required 1", freeze);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (freeze !== 1'b0 || priority_rotate !== 3'b111 || end_of_interrupt !== 8'h00 ||
            data_out_enable !== 1'b0 || int_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_gap: freeze=%b rot=%0d eoi=%h oe=%b int_out=%b required 0 7 00 0 1",
                     freeze, priority_rotate, end_of_interrupt, data_out_enable, int_out);
        end
        tick();
        checks++;
        if (end_of_interrupt !== 8'h00 || freeze !== 1'b0 || data_out_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_gap_after: eoi=%h freeze=%b oe=%b required 00 0 0",
                     end_of_interrupt, freeze, data_out_enable);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ack_sequence();
        test_aeoi();
        test_ocw2_commands();
        test_ns_eoi_empty();
        test_auto_rotate();
        test_back_to_back_ocw2_aeoi();
        test_spurious();
        test_reset_in_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_interrupt_ack_controller
`default_nettype wire

// File: doc/interrupt_ack_controller.md
INTERRUPT_ACK_CONTROLLER -- requirements
Module: interrupt_ack_controller

Interface
REQ-001 Parameters SHALL be none; all configuration arrives on ports.
REQ-002 clock  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inta_n  in  1  CPU interrupt-acknowledge, active low, synchronous to clock.
REQ-005 interrupt_request  in  8  one-hot winning request from priority resolver; 0 = none.
REQ-006 highest_level_in_service  in  8  one-hot highest in-service level from ISR.
REQ-007 ocw2_write  in  1  one-cycle OCW2 write strobe.
REQ-008 ocw2_data  in  8  OCW2: [7]=R, [6]=SL, [5]=EOI, [2:0]=L.
REQ-009 icw2_vector  in  5  vector base T7..T3.
REQ-010 auto_eoi  in  1  AEOI mode enable.
REQ-011 int_out  out  1  INT request to CPU.
REQ-012 interrupt  out  8  one-hot level to latch into ISR.
REQ-013 latch_in_service  out  1  one-cycle ISR latch strobe.
REQ-014 end_of_interrupt  out  8  one-hot ISR clear, one-cycle pulse.
REQ-015 priority_rotate  out  3  lowest-priority level for rotation.
REQ-016 freeze  out  1  holds IRR during acknowledge.
REQ-017 data_out  out  8  vector byte; data_out_enable  out  1  drives bus.

Function
REQ-018 inta_n SHALL be edge-detected against a registered copy; falling/rising edges valid one cycle after the transition.
REQ-019 FSM states SHALL be IDLE, ACK1, GAP, ACK2.
REQ-020 IDLE: int_out = 1 when interrupt_request != 0, else 0.
REQ-021 IDLE + inta_n falling: capture interrupt_request into ack_level (0 captured as spurious, level 7); drive interrupt = ack_level and latch_in_service = 1 for one cycle; freeze = 1; int_out = 0; go ACK1.
REQ-022 Spurious acknowledge SHALL keep interrupt = 0 (no ISR bit set) while still returning level-7 vector.
REQ-023 ACK1 + inta_n rising -> GAP; GAP + inta_n falling -> ACK2.
REQ-024 ACK2: data_out = {icw2_vector, encoded ack_level}, data_out_enable = 1 while in ACK2; 0 and data_out = 0 otherwise.
REQ-025 ACK2 + inta_n rising -> IDLE, freeze = 0; if auto_eoi and not spurious, end_of_interrupt = ack_level for one cycle; if auto_rotate set, priority_rotate = encoded ack_level.
REQ-026 OCW2 (R,SL,EOI), outputs registered one cycle after ocw2_write: 001 end_of_interrupt = highest_level_in_service; 011 end_of_interrupt = one-hot L; 101 as 001 plus priority_rotate = encoded highest; 111 as 011 plus priority_rotate = L; 110 priority_rotate = L, no EOI; 100 auto_rotate = 1; 000 auto_rotate = 0; 010 no action.
REQ-027 Non-specific EOI with highest_level_in_service = 0 SHALL produce end_of_interrupt = 0 and leave priority_rotate unchanged.
REQ-028 Simultaneous OCW2 EOI and AEOI SHALL OR both one-hots in the same pulse; OCW2 priority_rotate update wins.
REQ-029 ocw2_write SHALL be honoured in every FSM state.

Reset
REQ-030 reset SHALL force IDLE, inta_n copy = 1, ack_level = 0, auto_rotate = 0, priority_rotate = 3'b111, all other outputs 0.
REQ-031 reset mid-acknowledge SHALL abort with no EOI pulse and no vector drive.

Structure
REQ-032 Shared package pic_pkg SHALL hold the FSM state enum, OCW2 command encodings and the one-hot/encode helper functions.
REQ-033 No sub-module; edge detect and OCW2 decode are inline. Integration bench pairs it with in_service_register.

Verification
REQ-034 interrupt_request = 8'h08, icw2_vector = 5'b01000, two INTA pulses -> latch_in_service one cycle with interrupt = 8'h08, data_out = 8'h43 in ACK2, freeze high throughout.
REQ-035 auto_eoi = 1, request 8'h01, two INTA pulses -> end_of_interrupt = 8'h01 one cycle after second inta_n rising.
REQ-036 highest_level_in_service = 8'h20, ocw2_data = 8'hA0 -> end_of_interrupt = 8'h20 one cycle, priority_rotate = 3'd5.
REQ-037 ocw2_data = 8'hC3 -> priority_rotate = 3'd3, end_of_interrupt stays 0.
REQ-038 interrupt_request drops to 0 before first INTA -> interrupt = 0, data_out = {icw2_vector,3'd7}, no EOI under AEOI.
REQ-039 reset asserted in GAP -> next cycle IDLE, freeze = 0, priority_rotate = 3'b111, no EOI pulse.
